// File: rtl/ddr_wr_packer_pkg.sv
// Shared definitions for the DDR write packer: controller states and burst geometry.
package ddr_wr_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4
  } wr_state_t;

  localparam int unsigned BURST_WORDS        = 16;
  localparam int unsigned ADDR_STEP_PER_WORD = 8;

  // Words in the next command: a full burst, or whatever is left of the transfer.
  function automatic logic [31:0] chunk_words(input logic [31:0] remaining);
    return (remaining > 32'(BURST_WORDS)) ? 32'(BURST_WORDS) : remaining;
  endfunction

endpackage

// File: rtl/ddr_wr_fifo.sv
// Synchronous word FIFO with registered read data and an occupancy count.
module ddr_wr_fifo #(
  parameter  int DATA_W = 128,
  parameter  int DEPTH  = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only pointers, count and the read register do.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_wr_packer.sv
// Packs narrow input beats into DDR-width words, buffers them, and issues
// burst write commands of up to BURST_WORDS words until the transfer is complete.
module ddr_wr_packer
  import ddr_wr_packer_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int IN_WIDTH        = 32,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cfg_start,
  input  logic [CTRL_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [31:0]                cfg_total_words,
  input  logic                       in_valid,
  input  logic [IN_WIDTH-1:0]        in_data,
  output logic                       in_ready,
  output logic                       wr_cmd_en,
  output logic [CTRL_ADDR_WIDTH-1:0] wr_cmd_addr,
  output logic [31:0]                wr_cmd_len,
  input  logic                       wr_cmd_ready,
  input  logic                       wr_cmd_done,
  input  logic                       wr_data_re,
  output logic [MEM_DQ_WIDTH*8-1:0]  wr_ctrl_data,
  output logic                       busy,
  output logic                       xfer_done,
  output logic                       err_underflow
);

  localparam int W      = MEM_DQ_WIDTH * 8;
  localparam int LANES  = W / IN_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

  wr_state_t                  state;
  logic [CTRL_ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]                total_words;
  logic [31:0]                remaining;
  logic [31:0]                chunk;
  logic [31:0]                pack_words;
  logic [LANE_W-1:0]          lane;
  logic                       last_lane;
  logic                       beat_acc;
  logic                       start_xfer;
  logic [W-1:0]               pack_data_p1;
  logic                       pack_vld_p1;
  logic [CNT_W-1:0]           fifo_count;
  logic                       fifo_empty;
  logic [CNT_W:0]             fifo_occ;

  assign chunk      = chunk_words(remaining);
  assign start_xfer = (state == ST_IDLE) && cfg_start;
  assign last_lane  = (lane == LANE_W'(LANES - 1));
  assign beat_acc   = in_valid && in_ready;

  // A completed word waiting in pack_data_p1 already owns a FIFO slot.
  assign fifo_occ = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pack_vld_p1};
  // Completed words below the total means accepted beats below total*LANES.
  assign in_ready = busy && (fifo_occ < DEPTH_L) && (pack_words < total_words);

  // ---- stage p0 -> p1: lane assembly ----
  always_ff @(posedge clk) begin
    if (beat_acc) pack_data_p1[lane*IN_WIDTH +: IN_WIDTH] <= in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane          <= '0;
      pack_words    <= '0;
      pack_vld_p1   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      pack_vld_p1 <= beat_acc && last_lane;
      if (start_xfer) begin
        lane       <= '0;
        pack_words <= '0;
      end else if (beat_acc) begin
        lane <= last_lane ? '0 : lane + 1'b1;
        if (last_lane) pack_words <= pack_words + 32'd1;
      end
      if (wr_data_re && fifo_empty) err_underflow <= 1'b1;
    end
  end

  // ---- stage p1 -> FIFO ----
  ddr_wr_fifo #(
    .DATA_W (W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (pack_vld_p1),
    .push_data (pack_data_p1),
    .pop       (wr_data_re),
    .rd_data   (wr_ctrl_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Command sequencer. wr_cmd_addr/len are only reloaded on the next issue,
  // so they stay stable through WAIT_DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      xfer_done   <= 1'b0;
      wr_cmd_en   <= 1'b0;
      wr_cmd_addr <= '0;
      wr_cmd_len  <= '0;
      cur_addr    <= '0;
      total_words <= '0;
      remaining   <= '0;
    end else begin
      wr_cmd_en <= 1'b0;
      xfer_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            busy        <= 1'b1;
            cur_addr    <= cfg_base_addr;
            total_words <= cfg_total_words;
            remaining   <= cfg_total_words;
            if (cfg_total_words == 32'd0) begin
              xfer_done <= 1'b1;
              state     <= ST_FINISH;
            end else begin
              state <= ST_WAIT_DATA;
            end
          end
        end
        ST_WAIT_DATA: begin
          if ((32'(fifo_count) >= chunk) && wr_cmd_ready) begin
            wr_cmd_en   <= 1'b1;
            wr_cmd_addr <= cur_addr;
            wr_cmd_len  <= chunk;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (wr_cmd_done) begin
            cur_addr  <= cur_addr + CTRL_ADDR_WIDTH'(wr_cmd_len * ADDR_STEP_PER_WORD);
            remaining <= remaining - wr_cmd_len;
            if (remaining == wr_cmd_len) begin
              xfer_done <= 1'b1;
              state     <= ST_FINISH;
            end else begin
              state <= ST_WAIT_DATA;
            end
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_wr_packer.sv
// Randomized bench for ddr_wr_packer: a beat-queue reference model predicts
// packed words and command address/length sequences.
module tb_ddr_wr_packer;

  localparam int AW         = 28;
  localparam int W          = 128;
  localparam int IN_W       = 32;
  localparam int LANES      = W / IN_W;
  localparam int FIFO_DEPTH = 64;
  localparam logic [127:0] FIRST_WORD = 128'h00000003_00000002_00000001_00000000;

  logic            clk = 1'b0;
  logic            rstn;
  logic            cfg_start;
  logic [AW-1:0]   cfg_base_addr;
  logic [31:0]     cfg_total_words;
  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            in_ready;
  logic            wr_cmd_en;
  logic [AW-1:0]   wr_cmd_addr;
  logic [31:0]     wr_cmd_len;
  logic            wr_cmd_ready;
  logic            wr_cmd_done;
  logic            wr_data_re;
  logic [W-1:0]    wr_ctrl_data;
  logic            busy;
  logic            xfer_done;
  logic            err_underflow;

  int n_vec;
  int n_bad;

  always #5 clk = ~clk;

  ddr_wr_packer #(
    .CTRL_ADDR_WIDTH (AW),
    .MEM_DQ_WIDTH    (16),
    .IN_WIDTH        (IN_W),
    .FIFO_DEPTH      (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .cfg_start       (cfg_start),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_total_words (cfg_total_words),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .wr_cmd_en       (wr_cmd_en),
    .wr_cmd_addr     (wr_cmd_addr),
    .wr_cmd_len      (wr_cmd_len),
    .wr_cmd_ready    (wr_cmd_ready),
    .wr_cmd_done     (wr_cmd_done),
    .wr_data_re      (wr_data_re),
    .wr_ctrl_data    (wr_ctrl_data),
    .busy            (busy),
    .xfer_done       (xfer_done),
    .err_underflow   (err_underflow)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_busy"},      busy,          0);
    check({tag, "_in_ready"},  in_ready,      0);
    check({tag, "_cmd_en"},    wr_cmd_en,     0);
    check({tag, "_cmd_addr"},  wr_cmd_addr,   0);
    check({tag, "_cmd_len"},   wr_cmd_len,    0);
    check({tag, "_rdata"},     wr_ctrl_data,  0);
    check({tag, "_xfer_done"}, xfer_done,     0);
    check({tag, "_err"},       err_underflow, 0);
  endtask

  // One transfer: random source, a downstream that pops each command's words
  // and then acknowledges it. abort_at>0 returns while that command is outstanding.
  task automatic run_xfer(input logic [AW-1:0] base, input int total, input bit seq_data,
                          input int stall, input int abort_at);
    logic [31:0]  beats[$];
    logic [127:0] exp_w;
    logic [AW-1:0] exp_addr, hold_addr;
    logic [31:0]  exp_len, hold_len;
    int exp_rem, rd_idx, ncmd, pops_left, cyc;
    bit cmd_open, prev_en, pop_pend, fin;
    exp_addr = base; exp_rem = total; exp_len = 0; hold_addr = 0; hold_len = 0;
    rd_idx = 0; ncmd = 0; pops_left = 0; cyc = 0;
    cmd_open = 0; prev_en = 0; pop_pend = 0; fin = 0;
    cfg_base_addr = base; cfg_total_words = 32'(total); cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check("busy_start", busy, 1);
    while (!fin && cyc < 5000) begin
      if (pop_pend) begin
        exp_w = '1;
        for (int l = 0; l < LANES; l++)
          if (rd_idx*LANES + l < beats.size()) exp_w[l*IN_W +: IN_W] = beats[rd_idx*LANES + l];
        check("rd_data", wr_ctrl_data, exp_w);
        if (seq_data && rd_idx == 0) check("first_word", wr_ctrl_data, FIRST_WORD);
        rd_idx++;
        pop_pend = 0;
      end
      if (prev_en) begin
        check("cmd_en_width", wr_cmd_en, 0);
      end else if (wr_cmd_en) begin
        ncmd++;
        exp_len = (exp_rem > 16) ? 32'd16 : 32'(exp_rem);
        check("cmd_while_open", cmd_open, 0);
        check("cmd_addr", wr_cmd_addr, exp_addr);
        check("cmd_len", wr_cmd_len, exp_len);
        cmd_open = 1; pops_left = int'(exp_len); hold_addr = exp_addr; hold_len = exp_len;
      end else if (cmd_open) begin
        check("cmd_addr_hold", wr_cmd_addr, hold_addr);
        check("cmd_len_hold", wr_cmd_len, hold_len);
      end
      if (xfer_done) begin
        check("done_rem", exp_rem, 0);
        check("done_cmds", ncmd, (total + 15) / 16);
        check("beats_taken", beats.size(), total * LANES);
        fin = 1;
      end
      if (abort_at > 0 && ncmd == abort_at && cmd_open && !wr_cmd_en) return;
      if (beats.size() >= total * LANES) check("ready_limit", in_ready, 0);
      if (stall > 0 && cyc == stall - 1) begin
        check("bp_beats", beats.size(), FIFO_DEPTH * LANES);
        check("bp_ready", in_ready, 0);
      end
      // Stray start while busy carries different configuration that must be ignored.
      cfg_start = (total >= 16 && cyc == 5);
      if (cfg_start) begin
        cfg_base_addr = 28'h0ABCDE0; cfg_total_words = 32'd7;
      end
      wr_cmd_done = 1'b0;
      wr_data_re  = 1'b0;
      if (cmd_open) begin
        if (pops_left > 0) begin
          if ($urandom_range(3) != 0) begin
            wr_data_re = 1'b1; pop_pend = 1; pops_left--;
          end
        end else if ($urandom_range(1) == 1) begin
          wr_cmd_done = 1'b1; cmd_open = 0;
          exp_addr = exp_addr + AW'(exp_len * 8);
          exp_rem -= int'(exp_len);
        end
      end
      wr_cmd_ready = (cyc >= stall) && !cmd_open && ($urandom_range(7) != 0);
      in_valid = (stall > 0) ? 1'b1 : ($urandom_range(3) != 0);
      in_data  = seq_data ? 32'(beats.size()) : 32'($urandom);
      if (in_valid && in_ready) beats.push_back(in_data);
      prev_en = wr_cmd_en;
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin) check("xfer_timeout", 0, 1);
    in_valid = 1'b0; wr_data_re = 1'b0; wr_cmd_done = 1'b0; cfg_start = 1'b0;
    check("busy_end", busy, 0);
    check("done_pulse", xfer_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_bad = 0;
    rstn = 1'b0; cfg_start = 1'b0; cfg_base_addr = '0; cfg_total_words = '0;
    in_valid = 1'b0; in_data = '0; wr_cmd_ready = 1'b0; wr_cmd_done = 1'b0; wr_data_re = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outs("rst");
    rstn = 1'b1;
    @(posedge clk); #1;

    wr_cmd_done = 1'b1;
    @(posedge clk); #1;
    wr_cmd_done = 1'b0;
    check("idle_done_busy", busy, 0);
    check("idle_done_en", wr_cmd_en, 0);

    run_xfer(28'h0000100, 32, 1'b1, 0, 0);
    run_xfer(28'h0002000, 20, 1'b0, 0, 0);
    run_xfer(28'hFFFFFC0, 40, 1'b0, 0, 0);
    run_xfer(28'h0000040, 0,  1'b0, 0, 0);
    run_xfer(28'h0000400, 80, 1'b0, 400, 0);

    run_xfer(28'h0000300, 32, 1'b0, 0, 1);
    in_valid = 1'b0; wr_data_re = 1'b0; wr_cmd_done = 1'b0; wr_cmd_ready = 1'b0; cfg_start = 1'b0;
    #2 rstn = 1'b0;
    #1 check_zero_outs("abort");
    @(posedge clk); #1;
    rstn = 1'b1;

    wr_data_re = 1'b1;
    @(posedge clk); #1;
    wr_data_re = 1'b0;
    check("uf_set", err_underflow, 1);
    check("uf_rdata_hold", wr_ctrl_data, 0);
    repeat (3) @(posedge clk);
    #1;
    check("uf_sticky", err_underflow, 1);

    run_xfer(28'h0000500, 16, 1'b0, 0, 0);
    check("uf_sticky_xfer", err_underflow, 1);
    rstn = 1'b0;
    #1 check("uf_clear", err_underflow, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
